// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Execute stage that sits right after the ALU control decoder. It takes the
//   decoded 4-bit ALU control code and two register operands, computes the
//   result and the condition codes, and registers the result into the EX/MEM
//   boundary. Valid, stall and flush control that boundary register.
//
// Parameters
//   WIDTH      datapath width of the operands and the result (default 8)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   a decoded instruction is present this cycle
//   alu_ctrl   decoded ALU control code
//   op_a       first operand, R[ra]
//   op_b       second operand, R[rb]; the only operand of unary ops
//   stall      hold the EX/MEM register and the CCR
//   flush      kill the instruction being captured
//   ccr_save   interrupt entry: snapshot the CCR into the shadow register
//   ccr_rest   RTI: restore the CCR from the shadow register
//   out_valid  the EX/MEM register holds a live instruction
//   result     registered ALU result
//   ccr        current flags, {V,C,N,Z}
//
// Configuration
//   CCR_SHADOW_EN  when defined, adds the shadow CCR with save/restore.
//                  When undefined, ccr_save and ccr_rest are ignored.

module alu_exec_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             stall,
  input  logic             flush,
  input  logic             ccr_save,
  input  logic             ccr_rest,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       ccr
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_MOV  = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_AND  = 4'b0100,
    OP_OR   = 4'b0101,
    OP_RLC  = 4'b0110,
    OP_RRC  = 4'b0111,
    OP_SETC = 4'b1000,
    OP_CLRC = 4'b1001,
    OP_NOT  = 4'b1010,
    OP_NEG  = 4'b1011,
    OP_INC  = 4'b1100,
    OP_DEC  = 4'b1101
  } aluOpE;

  localparam int             MSB   = WIDTH - 1;
  localparam logic [WIDTH:0] ONE_W = (WIDTH + 1)'(1);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       ccr_q, ccr_d;
  logic [WIDTH-1:0] aluRes;
  logic [WIDTH:0]   wide;
  logic [3:0]       flagsNew;
  logic             updZN;
  logic             cap;

  assign cap = in_valid & ~stall & ~flush;

  // Datapath: one case per opcode. All carries and borrows come out of bit
  // WIDTH of a WIDTH+1 wide sum. Flags an op does not touch keep their
  // registered value. Z and N are filled in afterwards for ops that set them.
  // Rotates use the registered C. A stalled rotate is not captured, so it
  // cannot be applied twice.
  always_comb begin
    aluRes   = '0;
    wide     = '0;
    flagsNew = ccr_q;
    updZN    = 1'b0;
    case (alu_ctrl)
      OP_MOV: aluRes = op_b;
      OP_ADD: begin
        wide        = {1'b0, op_a} + {1'b0, op_b};
        aluRes      = wide[MSB:0];
        flagsNew[2] = wide[WIDTH];
        flagsNew[3] = (op_a[MSB] == op_b[MSB]) && (aluRes[MSB] != op_a[MSB]);
        updZN       = 1'b1;
      end
      OP_SUB: begin
        wide        = {1'b0, op_a} - {1'b0, op_b};
        aluRes      = wide[MSB:0];
        flagsNew[2] = wide[WIDTH];
        flagsNew[3] = (op_a[MSB] != op_b[MSB]) && (aluRes[MSB] != op_a[MSB]);
        updZN       = 1'b1;
      end
      OP_AND: begin
        aluRes = op_a & op_b;
        updZN  = 1'b1;
      end
      OP_OR: begin
        aluRes = op_a | op_b;
        updZN  = 1'b1;
      end
      OP_RLC: begin
        aluRes      = {op_b[MSB-1:0], ccr_q[2]};
        flagsNew[2] = op_b[MSB];
        updZN       = 1'b1;
      end
      OP_RRC: begin
        aluRes      = {ccr_q[2], op_b[MSB:1]};
        flagsNew[2] = op_b[0];
        updZN       = 1'b1;
      end
      OP_SETC: flagsNew[2] = 1'b1;
      OP_CLRC: flagsNew[2] = 1'b0;
      OP_NOT: begin
        aluRes = ~op_b;
        updZN  = 1'b1;
      end
      OP_NEG: begin
        // Zero minus b. The borrow out is set exactly when b is nonzero.
        wide        = {(WIDTH + 1){1'b0}} - {1'b0, op_b};
        aluRes      = wide[MSB:0];
        flagsNew[2] = wide[WIDTH];
        flagsNew[3] = op_b[MSB] && aluRes[MSB];
        updZN       = 1'b1;
      end
      OP_INC: begin
        wide        = {1'b0, op_b} + ONE_W;
        aluRes      = wide[MSB:0];
        flagsNew[2] = wide[WIDTH];
        flagsNew[3] = !op_b[MSB] && aluRes[MSB];
        updZN       = 1'b1;
      end
      OP_DEC: begin
        wide        = {1'b0, op_b} - ONE_W;
        aluRes      = wide[MSB:0];
        flagsNew[2] = wide[WIDTH];
        flagsNew[3] = op_b[MSB] && !aluRes[MSB];
        updZN       = 1'b1;
      end
      default: ;
    endcase
    if (updZN) begin
      flagsNew[0] = (aluRes == '0);
      flagsNew[1] = aluRes[MSB];
    end
  end

  // EX/MEM boundary. Flush beats stall, and stall beats load. An idle
  // cycle drops valid but keeps the last result visible.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    if (flush) begin
      valid_d  = 1'b0;
      result_d = '0;
    end else if (!stall) begin
      valid_d = in_valid;
      if (in_valid) result_d = aluRes;
    end
  end

`ifdef CCR_SHADOW_EN
  logic [3:0] shadow_q, shadow_d;

  // Save takes the CCR value from before this edge's update. Restore
  // overrides any flag update from the captured instruction. When save and
  // restore arrive together, the restore wins and the shadow keeps its value.
  // Stall does not gate either operation.
  always_comb begin
    ccr_d    = cap ? flagsNew : ccr_q;
    shadow_d = shadow_q;
    if (ccr_rest)      ccr_d    = shadow_q;
    else if (ccr_save) shadow_d = ccr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) shadow_q <= '0;
    else     shadow_q <= shadow_d;
  end
`else
  logic unusedShadowPorts;
  assign unusedShadowPorts = ccr_save ^ ccr_rest;

  always_comb begin
    ccr_d = cap ? flagsNew : ccr_q;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      ccr_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      ccr_q    <= ccr_d;
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign ccr       = ccr_q;

endmodule
